// File: rtl/ysyx_23060072_wb_regfile_pkg.sv
// Shared constants and helpers for the RV32E writeback register file.
package ysyx_23060072_wb_regfile_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 2;

    localparam logic [CNT_W-1:0]  SB_MAX   = 2'd3;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    // RV32E only has x0..x15, so an index is legal exactly when bit 4 is clear;
    // the compare form keeps every address bit in use.
    function automatic logic is_rv32e_reg(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(NUM_REGS);
    endfunction

    // Legal and not x0: the only indices that hold state or pending writes.
    function automatic logic is_wr_target(input logic [ADDR_W-1:0] a);
        return is_rv32e_reg(a) && (a != ZERO_REG);
    endfunction

endpackage

// File: rtl/ysyx_23060072_wb_regfile_if.sv
// Writeback bus from the writeback stage into the register file.
interface ysyx_23060072_wb_regfile_if;
    import ysyx_23060072_wb_regfile_pkg::*;

    logic              wb_flag;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (output wb_flag, output wb_addr, output wb_data);
    modport slave  (input  wb_flag, input  wb_addr, input  wb_data);

endinterface

// File: rtl/ysyx_23060072_wb_regfile_scoreboard.sv
// Per-register outstanding-write counters, issue gating and sticky protocol error.
module ysyx_23060072_scoreboard
    import ysyx_23060072_wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    input  logic              wb_flag_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              issue_ready_o,
    output logic              rs1_pend_o,
    output logic              rs2_pend_o,
    output logic              err_o
);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             err_q, err_d;
    logic             issue_hit, wb_hit, same_reg;
    logic [3:0]       issue_idx, wb_idx;

    assign issue_idx = issue_rd_i[3:0];
    assign wb_idx    = wb_addr_i[3:0];
    assign issue_hit = issue_valid_i && is_wr_target(issue_rd_i);
    assign wb_hit    = wb_flag_i && is_wr_target(wb_addr_i);
    assign same_reg  = issue_hit && wb_hit && (issue_rd_i == wb_addr_i);

    // Counter next state (flush > same-register cancel > inc/dec) and error detection.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (wb_flag_i && !is_rv32e_reg(wb_addr_i)) err_d = 1'b1;
        if (wb_hit && (cnt_q[wb_idx] == '0))        err_d = 1'b1;
        if (issue_hit && (cnt_q[issue_idx] == SB_MAX)) err_d = 1'b1;
        if (flush_i) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_d[i] = '0;
        end else if (!same_reg) begin
            if (issue_hit && (cnt_q[issue_idx] != SB_MAX))
                cnt_d[issue_idx] = cnt_q[issue_idx] + 2'd1;
            if (wb_hit && (cnt_q[wb_idx] != '0))
                cnt_d[wb_idx] = cnt_q[wb_idx] - 2'd1;
        end
    end

    // Counter and error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // A single pending write that is being written back right now is covered by the bypass.
    assign rs1_pend_o = is_wr_target(rs1_addr_i) &&
                        ((cnt_q[rs1_addr_i[3:0]] >= 2'd2) ||
                         ((cnt_q[rs1_addr_i[3:0]] == 2'd1) && !(wb_flag_i && (wb_addr_i == rs1_addr_i))));
    assign rs2_pend_o = is_wr_target(rs2_addr_i) &&
                        ((cnt_q[rs2_addr_i[3:0]] >= 2'd2) ||
                         ((cnt_q[rs2_addr_i[3:0]] == 2'd1) && !(wb_flag_i && (wb_addr_i == rs2_addr_i))));

    assign issue_ready_o = !(is_wr_target(issue_rd_i) && (cnt_q[issue_idx] == SB_MAX));
    assign err_o         = err_q;

endmodule

// File: rtl/ysyx_23060072_wb_regfile.sv
// RV32E register file: writeback commit, bypassed read ports and RAW stall.
module ysyx_23060072_wb_regfile
    import ysyx_23060072_wb_regfile_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    ysyx_23060072_wb_regfile_if.slave   wb,
    input  logic [ADDR_W-1:0]           rs1_addr_i,
    input  logic [ADDR_W-1:0]           rs2_addr_i,
    input  logic                        rs1_used_i,
    input  logic                        rs2_used_i,
    output logic [DATA_W-1:0]           rs1_data_o,
    output logic [DATA_W-1:0]           rs2_data_o,
    input  logic                        issue_valid_i,
    input  logic [ADDR_W-1:0]           issue_rd_i,
    output logic                        issue_ready_o,
    output logic                        raw_stall_o,
    input  logic                        flush_i,
    output logic                        err_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              rs1_pend, rs2_pend;

    // Data array; x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb.wb_flag && is_wr_target(wb.wb_addr)) begin
            regs_q[wb.wb_addr[3:0]] <= wb.wb_data;
        end
    end

    assign rs1_data_o = !is_wr_target(rs1_addr_i)                    ? '0 :
                        (wb.wb_flag && (wb.wb_addr == rs1_addr_i))   ? wb.wb_data :
                                                                       regs_q[rs1_addr_i[3:0]];
    assign rs2_data_o = !is_wr_target(rs2_addr_i)                    ? '0 :
                        (wb.wb_flag && (wb.wb_addr == rs2_addr_i))   ? wb.wb_data :
                                                                       regs_q[rs2_addr_i[3:0]];

    ysyx_23060072_scoreboard u_sb (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .wb_flag_i     (wb.wb_flag),
        .wb_addr_i     (wb.wb_addr),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .issue_ready_o (issue_ready_o),
        .rs1_pend_o    (rs1_pend),
        .rs2_pend_o    (rs2_pend),
        .err_o         (err_o)
    );

    assign raw_stall_o = (rs1_used_i && rs1_pend) || (rs2_used_i && rs2_pend);

endmodule
